systolic_west_feeder: RTL and testbench

//  Buffers input row-vectors and drives the west edge of the PE array.

---
 rtl/systolic_west_feeder_pkg.sv | 14 +
 rtl/systolic_west_feeder_skew_delay_line.sv | 29 ++
 rtl/systolic_west_feeder.sv | 156 +++++++++++++++
 tb/tb_systolic_west_feeder.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_west_feeder_pkg.sv
// Shared types for the systolic-array west-edge feeder: element type and feeder FSM states.
package tpu_pkg;

    localparam int DATA_WIDTH = 16;

    typedef logic signed [DATA_WIDTH-1:0] data_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } feeder_state_e;

endpackage

// File: rtl/systolic_west_feeder_skew_delay_line.sv
// Fixed-length register chain used to skew one array row; never stalls, async active-low clear.
module skew_delay_line #(
    parameter int STAGES = 1,
    parameter int WIDTH  = 18
) (
    input  logic             i_clk,
    input  logic             i_clr_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_stage [STAGES];

    always_ff @(posedge i_clk or negedge i_clr_n) begin
        if (!i_clr_n) begin
            for (int s = 0; s < STAGES; s++) begin
                r_stage[s] <= '0;
            end
        end else begin
            r_stage[0] <= i_d;
            for (int s = 1; s < STAGES; s++) begin
                r_stage[s] <= r_stage[s-1];
            end
        end
    end

    assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/systolic_west_feeder.sv
// Vector FIFO plus per-row diagonal skew driving the west edge of the PE array.
// Optional performance counters are enabled by defining FEEDER_PERF_CNT_EN.
module systolic_west_feeder
    import tpu_pkg::*;
#(
    parameter int ROWS       = 2,
    parameter int DATA_WIDTH = tpu_pkg::DATA_WIDTH,
    parameter int DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ROWS*DATA_WIDTH-1:0] in_data,
    input  logic                       in_switch,
    input  logic                       feed_en,
    output logic [ROWS*DATA_WIDTH-1:0] out_input,
    output logic [ROWS-1:0]            out_valid,
    output logic [ROWS-1:0]            out_switch,
    output logic                       busy
`ifdef FEEDER_PERF_CNT_EN
    ,
    output logic [31:0]                vec_count,
    output logic [31:0]                stall_count
`endif
);

    localparam int VEC_W = ROWS * DATA_WIDTH;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int DRN_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [DRN_W-1:0] DRN_LEN = DRN_W'((ROWS > 1) ? ROWS - 1 : 1);

    logic [VEC_W:0]   r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_ready_en;
    feeder_state_e    r_state;
    feeder_state_e    w_state_nxt;
    logic [DRN_W-1:0] r_drain_cnt;
    logic [DRN_W-1:0] w_drain_cnt_nxt;
    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic [VEC_W:0]   w_head;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == CNT_W'(DEPTH));
    assign w_pop    = feed_en && !w_empty;
    // r_ready_en holds in_ready low until the first edge after reset release.
    assign in_ready = r_ready_en && (!w_full || w_pop);
    assign w_push   = in_valid && in_ready;
    assign w_head   = r_mem[r_rd_ptr];
    assign busy     = (r_state != IDLE);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_switch, in_data};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ready_en  <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_state     <= IDLE;
            r_drain_cnt <= '0;
        end else begin
            r_ready_en  <= 1'b1;
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_cnt_nxt;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_drain_cnt_nxt = r_drain_cnt;
        unique case (r_state)
            IDLE: begin
                if (w_push) begin
                    w_state_nxt = STREAM;
                end
            end
            STREAM: begin
                if (w_pop && !w_push && (r_count == CNT_W'(1))) begin
                    w_state_nxt     = DRAIN;
                    w_drain_cnt_nxt = DRN_LEN;
                end
            end
            DRAIN: begin
                if (w_push) begin
                    w_state_nxt = STREAM;
                end else if (r_drain_cnt == DRN_W'(1)) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_drain_cnt_nxt = r_drain_cnt - DRN_W'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Non-pop cycles inject an all-zero bubble so data and switch stay 0 whenever valid is 0.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic [DATA_WIDTH+1:0] w_stage_in;
        logic [DATA_WIDTH+1:0] w_stage_out;

        assign w_stage_in = w_pop ? {1'b1, w_head[VEC_W], w_head[r*DATA_WIDTH +: DATA_WIDTH]} : '0;

        skew_delay_line #(
            .STAGES (r + 1),
            .WIDTH  (DATA_WIDTH + 2)
        ) u_skew (
            .i_clk   (clk),
            .i_clr_n (rst),
            .i_d     (w_stage_in),
            .o_q     (w_stage_out)
        );

        assign out_valid[r]                           = w_stage_out[DATA_WIDTH+1];
        assign out_switch[r]                          = w_stage_out[DATA_WIDTH];
        assign out_input[r*DATA_WIDTH +: DATA_WIDTH]  = w_stage_out[DATA_WIDTH-1:0];
    end

`ifdef FEEDER_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vec_count   <= '0;
            stall_count <= '0;
        end else begin
            if (w_pop && (vec_count != '1)) begin
                vec_count <= vec_count + 32'd1;
            end
            if (!w_empty && !feed_en && (stall_count != '1)) begin
                stall_count <= stall_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_systolic_west_feeder.sv
// Scoreboard bench for systolic_west_feeder (ROWS=2, DATA_WIDTH=16, DEPTH=4).
module tb_systolic_west_feeder;

    localparam int ROWS  = 2;
    localparam int DW    = 16;
    localparam int DEPTH = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_switch = 1'b0;
    logic                 feed_en = 1'b0;
    logic [ROWS*DW-1:0]   in_data = '0;
    logic                 in_ready;
    logic [ROWS*DW-1:0]   out_input;
    logic [ROWS-1:0]      out_valid;
    logic [ROWS-1:0]      out_switch;
    logic                 busy;
`ifdef FEEDER_PERF_CNT_EN
    logic [31:0]          vec_count;
    logic [31:0]          stall_count;
`endif

    int          checks = 0;
    int          failures = 0;
    logic [DW:0] exp_q0 [$];
    logic [DW:0] exp_q1 [$];
    logic [DW:0] e0;
    logic [DW:0] e1;
    bit          mon_en = 1'b0;
    logic        prev0 = 1'b0;
    int          run0 = 0;
    int          run1 = 0;
    int          last_run0 = 0;
    int          last_run1 = 0;

    always #5 clk = ~clk;

    systolic_west_feeder #(
        .ROWS       (ROWS),
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_switch  (in_switch),
        .feed_en    (feed_en),
        .out_input  (out_input),
        .out_valid  (out_valid),
        .out_switch (out_switch),
        .busy       (busy)
`ifdef FEEDER_PERF_CNT_EN
        ,
        .vec_count  (vec_count),
        .stall_count(stall_count)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic push_vec(input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic sw);
        int waited;
        waited    = 0;
        in_valid  = 1'b1;
        in_data   = {d1, d0};
        in_switch = sw;
        #1;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            chk("push_accept", in_ready, 1);
            in_valid = 1'b0;
            return;
        end
        exp_q0.push_back({sw, d0});
        exp_q1.push_back({sw, d1});
        @(negedge clk);
        in_valid  = 1'b0;
        in_switch = 1'b0;
    endtask

    // Monitor: pops the expected vector whenever a row presents valid data.
    always @(negedge clk) begin
        if (mon_en) begin
            if (out_valid[0]) begin
                if (exp_q0.size() == 0) begin
                    chk("row0_unexpected_valid", out_valid[0], 0);
                end else begin
                    e0 = exp_q0.pop_front();
                    chk("row0_data", out_input[DW-1:0], e0[DW-1:0]);
                    chk("row0_switch", out_switch[0], e0[DW]);
                end
            end else begin
                chk("row0_idle_data", out_input[DW-1:0], 0);
                chk("row0_idle_switch", out_switch[0], 0);
            end
            if (out_valid[1]) begin
                if (exp_q1.size() == 0) begin
                    chk("row1_unexpected_valid", out_valid[1], 0);
                end else begin
                    e1 = exp_q1.pop_front();
                    chk("row1_data", out_input[2*DW-1:DW], e1[DW-1:0]);
                    chk("row1_switch", out_switch[1], e1[DW]);
                end
            end else begin
                chk("row1_idle_data", out_input[2*DW-1:DW], 0);
                chk("row1_idle_switch", out_switch[1], 0);
            end
            chk("row1_skew", out_valid[1], prev0);
            prev0 = out_valid[0];
            if (out_valid[0]) run0++;
            else if (run0 != 0) begin last_run0 = run0; run0 = 0; end
            if (out_valid[1]) run1++;
            else if (run1 != 0) begin last_run1 = run1; run1 = 0; end
        end else begin
            prev0 = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_input", out_input, 0);
        chk("rst_out_switch", out_switch, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        rst = 1'b1;
        #1;
        chk("in_ready_before_first_edge", in_ready, 0);
        @(negedge clk);
        chk("in_ready_after_first_edge", in_ready, 1);
        mon_en = 1'b1;

        // Single vector timing
        feed_en = 1'b1;
        push_vec(16'h0100, 16'h0200, 1'b0);
        chk("t1_n1_valid", out_valid, 2'b00);
        chk("t1_n1_busy", busy, 1);
        @(negedge clk);
        chk("t1_n2_valid", out_valid, 2'b01);
        chk("t1_n2_in0", out_input[DW-1:0], 16'h0100);
        chk("t1_n2_busy", busy, 1);
        @(negedge clk);
        chk("t1_n3_valid", out_valid, 2'b10);
        chk("t1_n3_in1", out_input[2*DW-1:DW], 16'h0200);
        chk("t1_n3_busy", busy, 0);
        @(negedge clk);
        chk("t1_n4_valid", out_valid, 2'b00);
        repeat (2) @(negedge clk);
        chk("t1_run0", last_run0, 1);
        chk("t1_run1", last_run1, 1);

        // Fill FIFO, then stream with push+pop on full
        feed_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_vec(16'h1000 + 16'(i), 16'h2000 + 16'(i), 1'b0);
        end
        in_valid = 1'b1;
        #1;
        chk("t2_full_not_ready", in_ready, 0);
        @(negedge clk);
        chk("t2_no_pop_valid", out_valid, 2'b00);
        chk("t2_busy_full", busy, 1);
        feed_en = 1'b1;
        #1;
        chk("t3_full_ready_with_pop", in_ready, 1);
        push_vec(16'h1004, 16'h2004, 1'b0);
        push_vec(16'h1005, 16'h2005, 1'b0);
        repeat (10) @(negedge clk);
        chk("t2_run0_contig", last_run0, 6);
        chk("t2_run1_contig", last_run1, 6);
        chk("t2_busy_done", busy, 0);

        // Switch flag on vector 2 of 3
        push_vec(16'h3001, 16'h4001, 1'b0);
        push_vec(16'h3002, 16'h4002, 1'b1);
        push_vec(16'h3003, 16'h4003, 1'b0);
        repeat (6) @(negedge clk);
        chk("t4_run0", last_run0, 3);

        // Reset mid-stream
        feed_en = 1'b0;
        push_vec(16'h5001, 16'h6001, 1'b0);
        push_vec(16'h5002, 16'h6002, 1'b0);
        push_vec(16'h5003, 16'h6003, 1'b0);
        feed_en = 1'b1;
        @(negedge clk);
        #2;
        mon_en = 1'b0;
        rst = 1'b0;
        #1;
        chk("t5_async_valid", out_valid, 0);
        chk("t5_async_input", out_input, 0);
        chk("t5_async_switch", out_switch, 0);
        chk("t5_async_busy", busy, 0);
        chk("t5_async_in_ready", in_ready, 0);
        exp_q0.delete();
        exp_q1.delete();
        run0 = 0;
        run1 = 0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t5_in_ready_before_edge", in_ready, 0);
        mon_en = 1'b1;
        @(negedge clk);
        chk("t5_in_ready_after_edge", in_ready, 1);
        repeat (5) @(negedge clk);
        chk("t5_busy_after", busy, 0);

        // Perf-counter scenario: 2 stall cycles then 3 pops
        feed_en = 1'b0;
        push_vec(16'h7001, 16'h8001, 1'b0);
        push_vec(16'h7002, 16'h8002, 1'b1);
        push_vec(16'h7003, 16'h8003, 1'b0);
        feed_en = 1'b1;
        repeat (8) @(negedge clk);
        chk("t6_run0", last_run0, 3);
`ifdef FEEDER_PERF_CNT_EN
        chk("t6_vec_count", vec_count, 3);
        chk("t6_stall_count", stall_count, 2);
`endif

        chk("q0_drained", exp_q0.size(), 0);
        chk("q1_drained", exp_q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
